// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and constants for the nibble-serial add/sub scheduler
package addsub_pkg;

    localparam int NIB_W = 4;
    localparam int OP_W  = 8;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RSP  = 2'd3
    } state_t;

    // Round-robin pick between two requesters; on a tie the one not served last wins.
    function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic last);
        logic [1:0] g;
        if (valid == 2'b11) begin
            g = last ? 2'b01 : 2'b10;
        end else begin
            g = valid;
        end
        return g;
    endfunction

endpackage

// File: rtl/addsub4_core.sv
// rtl/addsub4_core.sv - combinational 4-bit adder/subtractor slice
module addsub4_core
    import addsub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] full;

    // Inversion follows sub alone so the high nibble can take the low nibble's borrow as cin.
    assign full = {1'b0, a} + {1'b0, b ^ {NIB_W{sub}}} + {{NIB_W{1'b0}}, cin};
    assign s    = full[NIB_W-1:0];
    assign cout = full[NIB_W];

endmodule

// File: rtl/addsub_sched.sv
// rtl/addsub_sched.sv - two-requester round-robin sequencer around one shared 4-bit add/sub core
module addsub_sched
    import addsub_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [OP_W-1:0] req_a0,
    input  logic [OP_W-1:0] req_b0,
    input  logic [OP_W-1:0] req_a1,
    input  logic [OP_W-1:0] req_b1,
    input  logic [1:0]      req_sub,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [OP_W-1:0] rsp_sum,
    output logic            rsp_cout,
    output logic            rsp_ovf,
    output logic            busy
);

    state_t state;
    state_t state_next;

    logic             last;
    logic [OP_W-1:0]  a_q;
    logic [OP_W-1:0]  b_q;
    logic             sub_q;
    logic             id_q;
    logic [NIB_W-1:0] lo_q;
    logic             c4_q;

    logic [NIB_W-1:0] core_a;
    logic [NIB_W-1:0] core_b;
    logic             core_cin;
    logic [NIB_W-1:0] core_s;
    logic             core_cout;

    logic             accept;
    logic             ovf_hi;

    assign accept = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = LO;
            LO:                     state_next = HI;
            HI:                     state_next = RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Grant is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        req_ready = 2'b00;
        busy      = 1'b1;
        core_a    = a_q[NIB_W-1:0];
        core_b    = b_q[NIB_W-1:0];
        core_cin  = sub_q;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (rst_n) begin
                    req_ready = rr_grant(req_valid, last);
                end
            end
            HI: begin
                core_a   = a_q[OP_W-1:NIB_W];
                core_b   = b_q[OP_W-1:NIB_W];
                core_cin = c4_q;
            end
            default: ;
        endcase
    end

    addsub4_core u_core (
        .a    (core_a),
        .b    (core_b),
        .sub  (sub_q),
        .cin  (core_cin),
        .s    (core_s),
        .cout (core_cout)
    );

    // Signed overflow: operands (after inversion) agree in sign but the result does not.
    assign ovf_hi = (a_q[OP_W-1] == (b_q[OP_W-1] ^ sub_q)) && (core_s[NIB_W-1] != a_q[OP_W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= ADD;
            id_q      <= 1'b0;
            lo_q      <= '0;
            c4_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= req_ready[1] ? req_a1 : req_a0;
                        b_q   <= req_ready[1] ? req_b1 : req_b0;
                        sub_q <= req_ready[1] ? req_sub[1] : req_sub[0];
                        id_q  <= req_ready[1];
                        last  <= req_ready[1];
                    end
                end
                LO: begin
                    lo_q <= core_s;
                    c4_q <= core_cout;
                end
                HI: begin
                    rsp_sum   <= {core_s, lo_q};
                    rsp_cout  <= core_cout;
                    rsp_ovf   <= ovf_hi;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_sched.sv
// tb/tb_addsub_sched.sv - randomized and directed self-checking bench for addsub_sched
module tb_addsub_sched;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0] req_sub;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_sum;
    logic       rsp_cout;
    logic       rsp_ovf;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int last_g = 1;

    addsub_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
    function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
        int ua, ub, sa, sb, ur, sr;
        logic c, v;
        logic [7:0] s;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        ur = sub ? ua - ub : ua + ub;
        sr = sub ? sa - sb : sa + sb;
        s  = 8'((ur + 256) % 256);
        c  = sub ? (ua >= ub) : (ur > 255);
        v  = (sr > 127) || (sr < -128);
        return {v, c, s};
    endfunction

    // Called at a negedge with the state expected to be IDLE and req_* already driven.
    task automatic txn(input int hold);
        int g;
        logic [7:0] a, b;
        logic s;
        logic [9:0] e;
        #1;
        if (req_valid == 2'b11) g = 1 - last_g;
        else g = req_valid[1] ? 1 : 0;
        chk("grant", {30'd0, req_ready}, 32'(1 << g));
        a = (g == 1) ? req_a1 : req_a0;
        b = (g == 1) ? req_b1 : req_b0;
        s = req_sub[g];
        e = ref_op(a, b, s);
        last_g = g;
        @(posedge clk);
        #1;
        repeat (2) begin
            @(negedge clk);
            chk("no_early_rsp", {31'd0, rsp_valid}, 0);
            chk("ready_while_busy", {30'd0, req_ready}, 0);
            chk("busy_mid", {31'd0, busy}, 1);
        end
        @(negedge clk);
        chk("rsp_valid", {31'd0, rsp_valid}, 1);
        chk("rsp_id", {31'd0, rsp_id}, g);
        chk("rsp_sum", {24'd0, rsp_sum}, {24'd0, e[7:0]});
        chk("rsp_cout", {31'd0, rsp_cout}, {31'd0, e[8]});
        chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, e[9]});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, rsp_valid}, 1);
            chk("hold_sum", {24'd0, rsp_sum}, {24'd0, e[7:0]});
            chk("hold_flags", {30'd0, rsp_ovf, rsp_cout}, {30'd0, e[9:8]});
            chk("hold_id", {31'd0, rsp_id}, g);
            chk("hold_ready", {30'd0, req_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 0);
    endtask

    task automatic set0(input logic [7:0] a, input logic [7:0] b, input logic sub);
        req_a0 = a;
        req_b0 = b;
        req_sub[0] = sub;
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        req_a0 = 8'h11; req_b0 = 8'h22;
        req_a1 = 8'hF0; req_b1 = 8'h0F;
        req_sub = 2'b01;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", {30'd0, req_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_rsp_outs", {21'd0, rsp_id, rsp_sum, rsp_cout, rsp_ovf}, 0);
        rst_n = 1'b1;
        last_g = 1;

        // Both requesters valid from reset: ids must alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            txn(0);
            chk("alternate", {31'd0, rsp_id}, 32'(i % 2));
        end

        // Directed arithmetic on requester 0 alone.
        req_valid = 2'b01;
        set0(8'h3A, 8'h15, 1'b0); txn(0);
        set0(8'h7F, 8'h01, 1'b0); txn(0);
        set0(8'hFF, 8'h01, 1'b0); txn(0);
        set0(8'h50, 8'h70, 1'b1); txn(5);
        set0(8'h80, 8'h01, 1'b1); txn(0);
        set0(8'h3C, 8'h0D, 1'b1); txn(2);

        // Requester 1 alone is granted every IDLE visit.
        req_valid = 2'b10;
        req_a1 = 8'h81; req_b1 = 8'h80; req_sub[1] = 1'b0;
        txn(0);
        txn(1);

        for (int i = 0; i < 24; i++) begin
            req_valid = 2'($urandom_range(1, 3));
            req_a0 = 8'($urandom); req_b0 = 8'($urandom);
            req_a1 = 8'($urandom); req_b1 = 8'($urandom);
            req_sub = 2'($urandom);
            txn($urandom_range(0, 3));
        end

        // Reset while the shared core is in the high-nibble step.
        req_valid = 2'b01;
        set0(8'h12, 8'h34, 1'b0);
        #1;
        chk("pre_rst_grant", {30'd0, req_ready}, 1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("midrst_req_ready", {30'd0, req_ready}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_rsp", {31'd0, rsp_valid}, 0);
        end
        req_valid = 2'b11;
        rst_n = 1'b1;
        last_g = 1;
        txn(0);
        chk("post_rst_tie", {31'd0, rsp_id}, 0);

        req_valid = 2'b00;
        @(negedge clk);
        chk("idle_no_grant", {30'd0, req_ready}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
